// File: rtl/dev_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dev_bus_arbiter
//  Description : Two-master arbiter/sequencer for the shared device bus
//                (Timer/Counter0-2 and LED port). Grants one transfer at a
//                time, round-robin on ties, and returns ACK/read data or a
//                timeout ERR to the owning master. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module dev_bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    // master 0 (CPU path)
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [31:0] M0_DAT_I,
    output logic [31:0] M0_DAT_O,
    output logic        M0_ACK_O,
    output logic        M0_ERR_O,
    // master 1 (debug/DMA)
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [31:0] M1_ADR_I,
    input  logic [31:0] M1_DAT_I,
    output logic [31:0] M1_DAT_O,
    output logic        M1_ACK_O,
    output logic        M1_ERR_O,
    // shared device bus
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I,
    // status
    output logic [1:0]  GNT_O,
    output logic        BUSY_O
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    logic          last_q;      // owner of the previous grant: 0=M0, 1=M1
    logic [CW-1:0] cnt_q;
    logic          stb_q;
    logic          we_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [1:0]    gnt_q;
    logic          m0_ack_q;
    logic          m0_err_q;
    logic [31:0]   m0_dat_q;
    logic          m1_ack_q;
    logic          m1_err_q;
    logic [31:0]   m1_dat_q;

    logic          req_d;       // at least one master is requesting
    logic          sel_m1_d;    // next owner if a grant is made: 1=M1

    // Arbitration decision: a lone requester wins; on a tie the master that
    // did not own the bus last time wins.
    always_comb begin
        req_d    = M0_STB_I | M1_STB_I;
        sel_m1_d = M1_STB_I & (~M0_STB_I | ~last_q);
    end

    // Sequencer FSM with all bus, status and response outputs registered.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            gnt_q    <= 2'b00;
            m0_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m0_dat_q <= '0;
            m1_ack_q <= 1'b0;
            m1_err_q <= 1'b0;
            m1_dat_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    m0_ack_q <= 1'b0;
                    m0_err_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    m1_err_q <= 1'b0;
                    gnt_q    <= 2'b00;
                    if (req_d) begin
                        stb_q   <= 1'b1;
                        we_q    <= sel_m1_d ? M1_WE_I  : M0_WE_I;
                        adr_q   <= sel_m1_d ? M1_ADR_I : M0_ADR_I;
                        dat_q   <= sel_m1_d ? M1_DAT_I : M0_DAT_I;
                        gnt_q   <= sel_m1_d ? 2'b10 : 2'b01;
                        last_q  <= sel_m1_d;
                        cnt_q   <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // ACK takes priority over a timeout on the same edge
                    if (ACK_I) begin
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (gnt_q[1]) begin
                            m1_ack_q <= 1'b1;
                            if (!we_q) begin
                                m1_dat_q <= DAT_I;
                            end
                        end else begin
                            m0_ack_q <= 1'b1;
                            if (!we_q) begin
                                m0_dat_q <= DAT_I;
                            end
                        end
                        state_q <= S_RELEASE;
                    end else if (cnt_q == CNT_LAST) begin
                        stb_q <= 1'b0;
                        if (gnt_q[1]) begin
                            m1_err_q <= 1'b1;
                        end else begin
                            m0_err_q <= 1'b1;
                        end
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    // Requests are not looked at here, so a master still
                    // holding STB during its ACK cycle is not re-granted.
                    m0_ack_q <= 1'b0;
                    m0_err_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    m1_err_q <= 1'b0;
                    gnt_q    <= 2'b00;
                    state_q  <= S_IDLE;
                end
                default: begin
                    stb_q   <= 1'b0;
                    gnt_q   <= 2'b00;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign STB_O    = stb_q;
    assign WE_O     = we_q;
    assign ADR_O    = adr_q;
    assign DAT_O    = dat_q;
    assign GNT_O    = gnt_q;
    assign BUSY_O   = (state_q != S_IDLE);
    assign M0_ACK_O = m0_ack_q;
    assign M0_ERR_O = m0_err_q;
    assign M0_DAT_O = m0_dat_q;
    assign M1_ACK_O = m1_ack_q;
    assign M1_ERR_O = m1_err_q;
    assign M1_DAT_O = m1_dat_q;

endmodule
`default_nettype wire

// File: tb/tb_dev_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dev_bus_arbiter
//  Description : Self-checking bench for dev_bus_arbiter. Expected grants and
//                responses are queued when a transfer is requested and
//                compared when the bus strobe rises / a pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dev_bus_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        RST_I;
    logic        M0_STB_I, M0_WE_I, M1_STB_I, M1_WE_I;
    logic [31:0] M0_ADR_I, M0_DAT_I, M1_ADR_I, M1_DAT_I;
    logic [31:0] M0_DAT_O, M1_DAT_O;
    logic        M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O;
    logic        STB_O, WE_O, ACK_I, BUSY_O;
    logic [31:0] ADR_O, DAT_O, DAT_I;
    logic [1:0]  GNT_O;

    dev_bus_arbiter #(.TIMEOUT(TO), .CW(8)) dut (
        .CLK_I(clk), .RST_I(RST_I),
        .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I), .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I),
        .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
        .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I), .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I),
        .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
        .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .ACK_I(ACK_I), .DAT_I(DAT_I), .GNT_O(GNT_O), .BUSY_O(BUSY_O)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          ack_cycle;   // STB cycle on which the slave acks; 0 = never
        logic [31:0] rdata;
        int          stb_len;
        int          busy_len;
    } grant_t;

    typedef struct {
        logic        mst;
        logic        err;
        logic        we;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic        mst;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          ack_cycle;
        logic [31:0] rdata;
        logic        exp_err;
        int          exp_stb;
    } vec_t;

    grant_t      gq[$];
    resp_t       rq[$];
    grant_t      cur;
    vec_t        vecs[8];
    int          n_cmp, n_err;
    int          m0_left, m1_left;
    logic [31:0] last_rd[2];
    logic        prev_stb, prev_busy, stray;
    int          stb_len, busy_len, scnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got an unexpected event, required none", name);
    endtask

    task automatic push_xfer(input logic mst, input logic we, input logic [31:0] adr,
                             input logic [31:0] wdat, input int ack_cycle,
                             input logic [31:0] rdata, input logic exp_err,
                             input int exp_stb, input int exp_busy, input bit with_resp);
        grant_t g;
        resp_t  r;
        g.gnt = mst ? 2'b10 : 2'b01;
        g.we = we; g.adr = adr; g.dat = wdat;
        g.ack_cycle = ack_cycle; g.rdata = rdata;
        g.stb_len = exp_stb; g.busy_len = exp_busy;
        gq.push_back(g);
        if (with_resp) begin
            r.mst = mst; r.err = exp_err; r.we = we; r.rdata = rdata;
            rq.push_back(r);
        end
        if (mst) begin
            M1_WE_I = we; M1_ADR_I = adr; M1_DAT_I = wdat; m1_left++; M1_STB_I = 1'b1;
        end else begin
            M0_WE_I = we; M0_ADR_I = adr; M0_DAT_I = wdat; m0_left++; M0_STB_I = 1'b1;
        end
    endtask

    // One cycle: observe outputs at the falling edge, check against the
    // scoreboard, then drive the slave and master models for the next edge.
    task automatic tick();
        logic [3:0] p, ep;
        resp_t      r;
        @(negedge clk);
        if (STB_O === 1'b1 && !prev_stb) begin
            if (gq.size() == 0) begin
                bad("grant");
            end else begin
                cur = gq.pop_front();
                chk("gnt", {30'd0, GNT_O}, {30'd0, cur.gnt});
                chk("adr", ADR_O, cur.adr);
                chk("dat", DAT_O, cur.dat);
                chk("we", {31'd0, WE_O}, {31'd0, cur.we});
            end
            stb_len = 0;
        end
        if (STB_O === 1'b1) stb_len++;
        else if (prev_stb) chk("stb_len", stb_len, cur.stb_len);
        if (BUSY_O === 1'b1) busy_len++;
        else if (prev_busy) begin
            chk("busy_len", busy_len, cur.busy_len);
            busy_len = 0;
        end
        p = {M1_ERR_O, M1_ACK_O, M0_ERR_O, M0_ACK_O};
        if (p !== 4'b0000) begin
            if (rq.size() == 0) begin
                bad("pulse");
            end else begin
                r  = rq.pop_front();
                ep = r.mst ? {r.err, ~r.err, 2'b00} : {2'b00, r.err, ~r.err};
                chk("pulse", {28'd0, p}, {28'd0, ep});
                if (!r.err && !r.we) last_rd[r.mst] = r.rdata;
            end
            if (p[1:0] != 2'b00 && m0_left > 0) m0_left--;
            if (p[3:2] != 2'b00 && m1_left > 0) m1_left--;
        end
        chk("m0_dat_o", M0_DAT_O, last_rd[0]);
        chk("m1_dat_o", M1_DAT_O, last_rd[1]);
        prev_stb  = (STB_O === 1'b1);
        prev_busy = (BUSY_O === 1'b1);
        if (STB_O === 1'b1) begin
            scnt++;
            ACK_I = (cur.ack_cycle != 0 && scnt == cur.ack_cycle);
        end else begin
            scnt  = 0;
            ACK_I = stray;
        end
        DAT_I    = ACK_I ? cur.rdata : 32'hDEAD_BEEF;
        M0_STB_I = (m0_left > 0);
        M1_STB_I = (m1_left > 0);
    endtask

    task automatic run_idle(input int maxc);
        int c;
        bit done;
        c = 0;
        done = 1'b0;
        while (!done && c < maxc) begin
            tick();
            c++;
            done = (m0_left == 0 && m1_left == 0 && BUSY_O === 1'b0 &&
                    gq.size() == 0 && rq.size() == 0);
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL run_idle: still busy after %0d cycles, required idle", maxc);
        end
        chk("idle_gnt", {30'd0, GNT_O}, 32'd0);
    endtask

    task automatic do_reset();
        RST_I = 1'b1;
        m0_left = 0; m1_left = 0;
        M0_STB_I = 1'b0; M1_STB_I = 1'b0;
        gq.delete(); rq.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        tick();
        tick();
        chk("rst_stb", {31'd0, STB_O}, 32'd0);
        chk("rst_we", {31'd0, WE_O}, 32'd0);
        chk("rst_adr", ADR_O, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_gnt", {30'd0, GNT_O}, 32'd0);
        chk("rst_busy", {31'd0, BUSY_O}, 32'd0);
        chk("rst_pulses", {28'd0, M1_ERR_O, M1_ACK_O, M0_ERR_O, M0_ACK_O}, 32'd0);
        RST_I = 1'b0;
    endtask

    initial begin
        int c;
        n_cmp = 0; n_err = 0;
        RST_I = 1'b1; ACK_I = 1'b0; DAT_I = '0; stray = 1'b0;
        M0_STB_I = 1'b0; M0_WE_I = 1'b0; M0_ADR_I = '0; M0_DAT_I = '0;
        M1_STB_I = 1'b0; M1_WE_I = 1'b0; M1_ADR_I = '0; M1_DAT_I = '0;
        prev_stb = 1'b0; prev_busy = 1'b0; stb_len = 0; busy_len = 0; scnt = 0;
        cur.gnt = 2'b00; cur.we = 1'b0; cur.adr = '0; cur.dat = '0;
        cur.ack_cycle = 0; cur.rdata = '0; cur.stb_len = 0; cur.busy_len = 0;

        //          mst   we    adr            wdat          ack rdata          err  stb
        vecs[0] = '{1'b0, 1'b0, 32'hA000_0204, 32'h0,        1,  32'h0000_00A5, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b0, 32'hA000_0300, 32'h0,        0,  32'h1111_1111, 1'b1, TO};
        vecs[2] = '{1'b1, 1'b0, 32'hA000_0300, 32'h0,        TO, 32'h5A5A_5A5A, 1'b0, TO};
        vecs[3] = '{1'b1, 1'b0, 32'hA000_0304, 32'h0,        15, 32'h0000_1234, 1'b0, 15};
        vecs[4] = '{1'b0, 1'b1, 32'hA000_0700, 32'h0000_00FF, 2, 32'h7777_7777, 1'b0, 2};
        vecs[5] = '{1'b0, 1'b0, 32'hA000_0208, 32'h0,        17, 32'h2222_2222, 1'b1, TO};
        vecs[6] = '{1'b1, 1'b1, 32'hA000_0400, 32'h0000_0003, 3, 32'h3333_3333, 1'b0, 3};
        vecs[7] = '{1'b0, 1'b0, 32'hA000_0200, 32'h0,        1,  32'hCAFE_0001, 1'b0, 1};

        do_reset();

        // simultaneous writes right after reset: M0 first, then M1
        push_xfer(1'b0, 1'b1, 32'hA000_0200, 32'h0000_0010, 1, 32'h0, 1'b0, 1, 2, 1'b1);
        push_xfer(1'b1, 1'b1, 32'hA000_0700, 32'h0000_0020, 1, 32'h0, 1'b0, 1, 2, 1'b1);
        run_idle(100);

        // single-master vectors: reads, writes, timeout and its boundaries
        for (int i = 0; i < 8; i++) begin
            push_xfer(vecs[i].mst, vecs[i].we, vecs[i].adr, vecs[i].wdat,
                      vecs[i].ack_cycle, vecs[i].rdata, vecs[i].exp_err,
                      vecs[i].exp_stb, vecs[i].exp_stb + 1, 1'b1);
            run_idle(100);
        end

        // stray ACK while idle must be ignored
        stray = 1'b1;
        repeat (3) tick();
        chk("stray_busy", {31'd0, BUSY_O}, 32'd0);
        chk("stray_gnt", {30'd0, GNT_O}, 32'd0);
        stray = 1'b0;
        tick();

        // fairness under continuous dual requests: 01,10,01,10,01,10
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_xfer(1'b0, 1'b0, 32'hA000_0400, 32'h0, 1, 32'h0000_0100 + i, 1'b0, 1, 2, 1'b1);
            push_xfer(1'b1, 1'b0, 32'hA000_0404, 32'h0, 1, 32'h0000_0200 + i, 1'b0, 1, 2, 1'b1);
        end
        run_idle(200);

        // reset on the second BUSY cycle of an M0 read
        do_reset();
        push_xfer(1'b0, 1'b0, 32'hA000_0208, 32'h0, 0, 32'h0, 1'b1, 2, 2, 1'b0);
        c = 0;
        while (STB_O !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        n_cmp++;
        if (STB_O !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rst_stb_rise: got %b, required 1", STB_O);
        end
        tick();
        RST_I = 1'b1;
        last_rd[0] = '0; last_rd[1] = '0;
        tick();
        chk("mid_rst_stb", {31'd0, STB_O}, 32'd0);
        chk("mid_rst_gnt", {30'd0, GNT_O}, 32'd0);
        chk("mid_rst_busy", {31'd0, BUSY_O}, 32'd0);
        chk("mid_rst_pulses", {28'd0, M1_ERR_O, M1_ACK_O, M0_ERR_O, M0_ACK_O}, 32'd0);
        RST_I = 1'b0;
        m0_left = 0;
        push_xfer(1'b0, 1'b0, 32'hA000_0208, 32'h0, 1, 32'h0000_0077, 1'b0, 1, 2, 1'b1);
        push_xfer(1'b1, 1'b0, 32'hA000_0704, 32'h0, 1, 32'h0000_0088, 1'b0, 1, 2, 1'b1);
        run_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
